// File: rtl/game_pkg.sv
// game_pkg: shared types, widths and BCD helpers for the game timer
package game_pkg;
    typedef enum logic [1:0] {RUN, ADJ, EXPIRED} state_t;
    localparam int SEG_W = 7;
    localparam int BCD_W = 4;
    localparam int MAX_DIGITS = 6;
    localparam int BIN_W = 20;

    // Elaboration-time conversion of a binary constant to packed BCD
    function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int unsigned v);
        logic [BCD_W*MAX_DIGITS-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[BCD_W*i +: BCD_W] = BCD_W'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Packed BCD back to binary, used for the remaining-time comparison
    function automatic logic [BIN_W-1:0] bcd2bin(input logic [BCD_W*MAX_DIGITS-1:0] b);
        logic [BIN_W-1:0] r;
        r = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--)
            r = r * BIN_W'(10) + BIN_W'(b[BCD_W*i +: BCD_W]);
        return r;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade counter; steps only when its carry/borrow input is set
module bcd_digit
    import game_pkg::*;
#(
    parameter logic [BCD_W-1:0] INIT = '0
)(
    input  logic             Clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic             cin,
    output logic [BCD_W-1:0] q,
    output logic [BCD_W-1:0] nxt,
    output logic             cout
);
    assign cout = cin && ((inc && q == 4'd9) || (dec && q == 4'd0));
    assign nxt  = !cin ? q :
                  inc  ? (q == 4'd9 ? 4'd0 : q + 4'd1) :
                  dec  ? (q == 4'd0 ? 4'd9 : q - 4'd1) : q;

    // Reset and reload share the start digit; otherwise commit the stepped value
    always_ff @(posedge Clock)
        if (!reset || load)
            q <= INIT;
        else if (en)
            q <= nxt;
endmodule

// File: rtl/hex_decoder.sv
// hex_decoder: 4-bit value to active-low seven-segment pattern (bit 0 = segment a)
module hex_decoder
    import game_pkg::*;
(
    input  logic [BCD_W-1:0] c,
    output logic [SEG_W-1:0] display
);
    // Segment lookup
    always_comb begin
        case (c)
            4'h0: display = 7'b1000000;
            4'h1: display = 7'b1111001;
            4'h2: display = 7'b0100100;
            4'h3: display = 7'b0110000;
            4'h4: display = 7'b0011001;
            4'h5: display = 7'b0010010;
            4'h6: display = 7'b0000010;
            4'h7: display = 7'b1111000;
            4'h8: display = 7'b0000000;
            4'h9: display = 7'b0010000;
            4'ha: display = 7'b0001000;
            4'hb: display = 7'b0000011;
            4'hc: display = 7'b1000110;
            4'hd: display = 7'b0100001;
            4'he: display = 7'b0000110;
            default: display = 7'b0001110;
        endcase
    end
endmodule

// File: rtl/game_timer_bcd.sv
// game_timer_bcd: BCD game clock with expiry, warning, reload and adjust channel
module game_timer_bcd
    import game_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int LIMIT    = 120,
    parameter int COUNT_UP = 0,
    parameter int WARN     = 10
)(
    input  logic                    Clock,
    input  logic                    reset,
    input  logic                    masterEnable,
    input  logic                    enableDC,
    input  logic                    load,
    input  logic                    adjValid,
    input  logic                    adjUp,
    input  logic [7:0]              adjAmount,
    output logic                    adjReady,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic [SEG_W*DIGITS-1:0] hex,
    output logic                    expired,
    output logic                    expirePulse,
    output logic                    warning
);
    localparam int BW = BCD_W * DIGITS;
    localparam logic UP_MODE = COUNT_UP != 0;
    localparam logic [BCD_W*MAX_DIGITS-1:0] START_F = to_bcd(UP_MODE ? 0 : LIMIT);
    localparam logic [BCD_W*MAX_DIGITS-1:0] TERM_F  = to_bcd(UP_MODE ? LIMIT : 0);
    localparam logic [BW-1:0] START = START_F[BW-1:0];
    localparam logic [BW-1:0] TERM  = TERM_F[BW-1:0];

    state_t                    state, state_n;
    logic [7:0]                pending, pend_n;
    logic                      adj_dir, dir_n;
    logic                      tick, step_up, write, hit, blocked;
    logic [BW-1:0]             nxt;
    logic [DIGITS:0]           carry;
    logic [BCD_W*MAX_DIGITS-1:0] bcd_pad;
    logic [BIN_W-1:0]          bin, rem;

    assign tick     = masterEnable && enableDC;
    assign adjReady = state == RUN && !load;
    // A tick always steps in the mode direction; only an adjust step uses adj_dir
    assign step_up  = (state == ADJ && !enableDC) ? adj_dir : UP_MODE;
    assign carry[0] = 1'b1;
    // Carry out of the top digit means the step would wrap past 0 or all-nines
    assign blocked  = carry[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit #(.INIT(START[BCD_W*i +: BCD_W])) u_digit (
            .Clock (Clock),
            .reset (reset),
            .load  (load),
            .en    (write),
            .inc   (step_up),
            .dec   (!step_up),
            .cin   (carry[i]),
            .q     (bcd[BCD_W*i +: BCD_W]),
            .nxt   (nxt[BCD_W*i +: BCD_W]),
            .cout  (carry[i+1])
        );
        hex_decoder u_hex (
            .c       (bcd[BCD_W*i +: BCD_W]),
            .display (hex[SEG_W*i +: SEG_W])
        );
    end

    assign bcd_pad = (BCD_W*MAX_DIGITS)'(bcd);
    assign bin     = bcd2bin(bcd_pad);
    assign rem     = UP_MODE ? BIN_W'(LIMIT) - bin : bin;
    assign warning = rem <= BIN_W'(WARN) && !expired;

    // Next state, pending count and digit write enable; load overrides everything
    always_comb begin
        state_n = state;
        pend_n  = pending;
        dir_n   = adj_dir;
        write   = 1'b0;
        hit     = 1'b0;
        case (state)
            RUN: begin
                write = tick && !blocked;
                if (adjValid && adjReady) begin
                    state_n = ADJ;
                    pend_n  = adjAmount;
                    dir_n   = adjUp;
                end
            end
            ADJ: begin
                if (tick)
                    write = !blocked;
                else if (masterEnable) begin
                    if (pending == 8'd0 || blocked) begin
                        state_n = RUN;
                        pend_n  = 8'd0;
                    end else begin
                        write  = 1'b1;
                        pend_n = pending - 8'd1;
                        if (pending == 8'd1)
                            state_n = RUN;
                    end
                end
            end
            default: ;
        endcase
        hit = write && nxt == TERM;
        if (hit) begin
            state_n = EXPIRED;
            pend_n  = 8'd0;
        end
        if (load) begin
            state_n = RUN;
            pend_n  = 8'd0;
            write   = 1'b0;
            hit     = 1'b0;
        end
    end

    // FSM, adjust registers and expiry flags
    always_ff @(posedge Clock)
        if (!reset) begin
            state       <= RUN;
            pending     <= 8'd0;
            adj_dir     <= 1'b0;
            expired     <= 1'b0;
            expirePulse <= 1'b0;
        end else begin
            state       <= state_n;
            pending     <= pend_n;
            adj_dir     <= dir_n;
            expired     <= !load && (expired || hit);
            expirePulse <= hit;
        end
endmodule

// File: tb/tb_game_timer_bcd.sv
// tb_game_timer_bcd: directed checks of countdown and count-up game timers
module tb_game_timer_bcd;
    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        reset, masterEnable, enableDC, load, adjValid, adjUp;
    logic [7:0]  adjAmount;
    logic        adjReady, expired, expirePulse, warning;
    logic [11:0] bcd;
    logic [20:0] hex;

    logic        me2, tick2;
    logic        rdy2, exp2, pls2, warn2;
    logic [7:0]  bcd2;
    logic [13:0] hex2;

    game_timer_bcd dut (
        .Clock(Clock), .reset(reset), .masterEnable(masterEnable), .enableDC(enableDC),
        .load(load), .adjValid(adjValid), .adjUp(adjUp), .adjAmount(adjAmount),
        .adjReady(adjReady), .bcd(bcd), .hex(hex), .expired(expired),
        .expirePulse(expirePulse), .warning(warning)
    );

    game_timer_bcd #(.DIGITS(2), .LIMIT(59), .COUNT_UP(1), .WARN(10)) dut_up (
        .Clock(Clock), .reset(reset), .masterEnable(me2), .enableDC(tick2),
        .load(1'b0), .adjValid(1'b0), .adjUp(1'b0), .adjAmount(8'd0),
        .adjReady(rdy2), .bcd(bcd2), .hex(hex2), .expired(exp2),
        .expirePulse(pls2), .warning(warn2)
    );

    typedef struct {
        logic        tick, ld, av, au;
        logic [7:0]  amt;
        logic [11:0] e_bcd;
        logic        e_rdy, e_exp, e_pls, e_warn;
    } vec_t;

    vec_t tbl [23];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
        enableDC = 1'b0;
        load     = 1'b0;
        adjValid = 1'b0;
        tick2    = 1'b0;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            enableDC = 1'b1;
            cyc();
        end
    endtask

    initial begin
        int pulses;
        logic [11:0] wb;
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 12'h010, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h011, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h012, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h013, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h014, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h015, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'h014, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'h013, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'h012, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'h011, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'h010, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 12'h010, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h011, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'h010, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h011, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h012, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h013, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h014, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 12'h014, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h013, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 12'h120, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 12'h120, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h120, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b0; masterEnable = 1'b1; enableDC = 1'b1; load = 1'b0;
        adjValid = 1'b0; adjUp = 1'b0; adjAmount = 8'd0; me2 = 1'b1; tick2 = 1'b1;
        cyc();
        chk("reset bcd", 32'(bcd), 32'h120);
        chk("reset ready", 32'(adjReady), 32'd1);
        chk("reset expired", 32'(expired), 32'd0);
        chk("reset pulse", 32'(expirePulse), 32'd0);
        chk("reset warning", 32'(warning), 32'd0);
        chk("up reset bcd", 32'(bcd2), 32'h00);
        chk("up reset ready", 32'(rdy2), 32'd1);
        reset = 1'b1;

        ticks(20);
        chk("at 100", 32'(bcd), 32'h100);
        ticks(1);
        chk("borrow 099", 32'(bcd), 32'h099);
        chk("hex d0", 32'(hex[6:0]), 32'h10);
        chk("hex d1", 32'(hex[13:7]), 32'h10);
        chk("hex d2", 32'(hex[20:14]), 32'h40);
        ticks(88);
        chk("at 011", 32'(bcd), 32'h011);
        chk("warn 011", 32'(warning), 32'd0);
        ticks(1);
        chk("at 010", 32'(bcd), 32'h010);
        chk("warn 010", 32'(warning), 32'd1);

        for (int i = 0; i < 23; i++) begin
            enableDC  = tbl[i].tick;
            load      = tbl[i].ld;
            adjValid  = tbl[i].av;
            adjUp     = tbl[i].au;
            adjAmount = tbl[i].amt;
            cyc();
            chk($sformatf("v%0d bcd", i), 32'(bcd), 32'(tbl[i].e_bcd));
            chk($sformatf("v%0d ready", i), 32'(adjReady), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d expired", i), 32'(expired), 32'(tbl[i].e_exp));
            chk($sformatf("v%0d pulse", i), 32'(expirePulse), 32'(tbl[i].e_pls));
            chk($sformatf("v%0d warning", i), 32'(warning), 32'(tbl[i].e_warn));
        end

        ticks(113);
        chk("at 007", 32'(bcd), 32'h007);
        adjValid = 1'b1; adjUp = 1'b0; adjAmount = 8'd20;
        cyc();
        chk("clamp hs bcd", 32'(bcd), 32'h007);
        chk("clamp hs ready", 32'(adjReady), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("clamp step %0d", k), 32'(bcd), 32'(7 - k));
        end
        cyc();
        chk("clamp bcd", 32'(bcd), 32'h000);
        chk("clamp expired", 32'(expired), 32'd1);
        chk("clamp pulse", 32'(expirePulse), 32'd1);
        chk("clamp ready", 32'(adjReady), 32'd0);
        chk("clamp warning", 32'(warning), 32'd0);
        enableDC = 1'b1;
        cyc();
        chk("expired tick bcd", 32'(bcd), 32'h000);
        chk("expired pulse once", 32'(expirePulse), 32'd0);
        chk("expired hold", 32'(expired), 32'd1);
        chk("expired ready", 32'(adjReady), 32'd0);
        load = 1'b1;
        cyc();
        chk("reload bcd", 32'(bcd), 32'h120);
        chk("reload expired", 32'(expired), 32'd0);
        chk("reload ready", 32'(adjReady), 32'd1);

        pulses = 0;
        wb = 12'hfff;
        for (int k = 0; k < 120; k++) begin
            enableDC = 1'b1;
            cyc();
            pulses += int'(expirePulse);
            if (warning && wb == 12'hfff) wb = bcd;
        end
        chk("full bcd", 32'(bcd), 32'h000);
        chk("full expired", 32'(expired), 32'd1);
        chk("full pulses", 32'(pulses), 32'd1);
        chk("warning rise", 32'(wb), 32'h010);
        ticks(1);
        chk("tick 121 bcd", 32'(bcd), 32'h000);
        chk("tick 121 pulse", 32'(expirePulse), 32'd0);

        me2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick2 = 1'b1;
            cyc();
        end
        chk("up paused", 32'(bcd2), 32'h00);
        me2 = 1'b1;
        pulses = 0;
        for (int k = 0; k < 48; k++) begin
            tick2 = 1'b1;
            cyc();
            pulses += int'(pls2);
        end
        chk("up at 48", 32'(bcd2), 32'h48);
        chk("up warn 48", 32'(warn2), 32'd0);
        tick2 = 1'b1;
        cyc();
        chk("up at 49", 32'(bcd2), 32'h49);
        chk("up warn 49", 32'(warn2), 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick2 = 1'b1;
            cyc();
            pulses += int'(pls2);
        end
        chk("up at 59", 32'(bcd2), 32'h59);
        chk("up expired", 32'(exp2), 32'd1);
        chk("up pulse", 32'(pls2), 32'd1);
        chk("up pulses", 32'(pulses), 32'd1);
        chk("up warn expired", 32'(warn2), 32'd0);
        chk("up hex d0", 32'(hex2[6:0]), 32'h10);
        chk("up hex d1", 32'(hex2[13:7]), 32'h12);
        tick2 = 1'b1;
        cyc();
        chk("up hold", 32'(bcd2), 32'h59);
        chk("up pulse once", 32'(pls2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
